// File: rtl/alu_writeback_pkg.sv
// Shared constants and helpers for the ALU writeback stage: data width, status-flag bit
// positions and the per-result flag computation.
package alu_writeback_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 3;
    localparam int FLAG_W     = 4;

    localparam int FLAG_SHIFT_OVF = 0;
    localparam int FLAG_ARITH_OVF = 1;
    localparam int FLAG_ZERO      = 2;
    localparam int FLAG_NEG       = 3;

    // One ALU result as held in the stage register (destination kept separately, it is parameterised).
    typedef struct packed {
        logic              wr_en;
        logic              flag_en;
        logic [DATA_W-1:0] result;
        logic              shift_ovf;
        logic              arith_ovf;
    } stage_t;

    function automatic logic [FLAG_W-1:0] result_flags(input logic [DATA_W-1:0] result,
                                                       input logic              arith_ovf,
                                                       input logic              shift_ovf);
        logic [FLAG_W-1:0] f;
        f                 = '0;
        f[FLAG_NEG]       = result[DATA_W-1];
        f[FLAG_ZERO]      = (result == '0);
        f[FLAG_ARITH_OVF] = arith_ovf;
        f[FLAG_SHIFT_OVF] = shift_ovf;
        return f;
    endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// ALU-result bus into the writeback stage: valid/ready handshake plus the result payload.
interface alu_writeback_if #(
    parameter int ADDR_W = 3
);
    import alu_writeback_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic              flag_en;
    logic [ADDR_W-1:0] dest_addr;
    logic [DATA_W-1:0] result;
    logic              shift_ovf;
    logic              arith_ovf;

    modport master (
        output in_valid, wr_en, flag_en, dest_addr, result, shift_ovf, arith_ovf,
        input  in_ready
    );

    modport slave (
        input  in_valid, wr_en, flag_en, dest_addr, result, shift_ovf, arith_ovf,
        output in_ready
    );

endinterface

// File: rtl/alu_writeback_reg_file.sv
// General register file: NUM_REGS x 8 bits, one synchronous write port, two asynchronous
// read ports, register 0 hardwired to zero.
module alu_writeback_reg_file
    import alu_writeback_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem [NUM_REGS];

    // NOTE: the file is architectural state that must read as zero after reset, so every
    // entry is cleared; a plain data buffer would normally be left unreset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: one-cycle stage register, commit to register file and status flags,
// bypassed operand read ports. Define WB_STICKY_FLAGS_EN for accumulating overflow flags.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic               clk,
    input  logic               reset_n,
    alu_writeback_if.slave     alu,
    input  logic               hold,
    input  logic               flag_clear,
    input  logic [ADDR_W-1:0]  rd_addr_a,
    input  logic [ADDR_W-1:0]  rd_addr_b,
    output logic [DATA_W-1:0]  rd_data_a,
    output logic [DATA_W-1:0]  rd_data_b,
    output logic [FLAG_W-1:0]  flags,
    output logic               commit
);

    logic              accept;
    logic              s_valid;
    stage_t            stage;
    logic [ADDR_W-1:0] s_dest;
    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_next;
    logic              flag_update;
    logic              clear_flags;
    logic [DATA_W-1:0] rf_data_a;
    logic [DATA_W-1:0] rf_data_b;

    assign alu.in_ready = reset_n & ~hold;
    assign accept       = alu.in_valid & alu.in_ready;
    assign flag_update  = s_valid & stage.flag_en;

`ifdef WB_STICKY_FLAGS_EN
    assign clear_flags = flag_clear;
`else
    // Non-sticky flags are fully overwritten on every update, so a clear request has no effect.
    assign clear_flags = flag_clear & 1'b0;
`endif

    // NOTE: next-state logic gets its default first so no path through the block leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        flags_next = result_flags(stage.result, stage.arith_ovf, stage.shift_ovf);
`ifdef WB_STICKY_FLAGS_EN
        flags_next[FLAG_ARITH_OVF] = flags_next[FLAG_ARITH_OVF] | flags_q[FLAG_ARITH_OVF];
        flags_next[FLAG_SHIFT_OVF] = flags_next[FLAG_SHIFT_OVF] | flags_q[FLAG_SHIFT_OVF];
`endif
    end

    // NOTE: state is updated with non-blocking assignments so every register samples the
    // pre-edge values, letting the old entry commit while the new one latches.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s_valid <= 1'b0;
            stage   <= '0;
            s_dest  <= '0;
            flags_q <= '0;
        end else begin
            s_valid <= accept;
            if (accept) begin
                stage  <= '{wr_en:     alu.wr_en,
                            flag_en:   alu.flag_en,
                            result:    alu.result,
                            shift_ovf: alu.shift_ovf,
                            arith_ovf: alu.arith_ovf};
                s_dest <= alu.dest_addr;
            end
            // A flag-updating commit takes priority over a clear in the same cycle.
            if (flag_update) begin
                flags_q <= flags_next;
            end else if (clear_flags) begin
                flags_q <= '0;
            end
        end
    end

    alu_writeback_reg_file #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_reg_file (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (s_valid & stage.wr_en),
        .waddr   (s_dest),
        .wdata   (stage.result),
        .raddr_a (rd_addr_a),
        .raddr_b (rd_addr_b),
        .rdata_a (rf_data_a),
        .rdata_b (rf_data_b)
    );

    // Bypass the pending entry so a dependent op issued right behind it needs no stall.
    always_comb begin
        rd_data_a = rf_data_a;
        rd_data_b = rf_data_b;
        if ((rd_addr_a != '0) && s_valid && stage.wr_en && (s_dest == rd_addr_a)) begin
            rd_data_a = stage.result;
        end
        if ((rd_addr_b != '0) && s_valid && stage.wr_en && (s_dest == rd_addr_b)) begin
            rd_data_b = stage.result;
        end
    end

    assign flags  = flags_q;
    assign commit = s_valid;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed scenarios plus randomized traffic against
// a queue-based reference model of the register file and status flags.
`timescale 1ns/1ps
module tb_alu_writeback;
    import alu_writeback_pkg::*;

`ifdef WB_STICKY_FLAGS_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic       hold;
    logic       flag_clear;
    logic [2:0] rd_addr_a;
    logic [2:0] rd_addr_b;
    logic [7:0] rd_data_a;
    logic [7:0] rd_data_b;
    logic [3:0] flags;
    logic       commit;

    int passed = 0;
    int total  = 0;

    alu_writeback_if #(.ADDR_W(3)) bus ();

    alu_writeback #(.NUM_REGS(8), .ADDR_W(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .alu        (bus.slave),
        .hold       (hold),
        .flag_clear (flag_clear),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .flags      (flags),
        .commit     (commit)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: architectural registers, flags and the list of accepted-but-uncommitted ops.
    typedef struct {
        bit          wr;
        bit          fl;
        int unsigned dest;
        byte unsigned res;
        bit          sovf;
        bit          aovf;
    } op_t;

    byte unsigned m_regs [8];
    bit [3:0]     m_flags;
    op_t          m_pend [$];

    function automatic logic [7:0] exp_read(input logic [2:0] a);
        if (a == 3'd0) return 8'h00;
        foreach (m_pend[i]) if (m_pend[i].wr && m_pend[i].dest == a) return m_pend[i].res;
        return m_regs[a];
    endfunction

    task automatic tick();
        bit  rst_now;
        bit  acc;
        bit  clr;
        bit  fupd;
        op_t nop;
        op_t o;
        rst_now = !reset_n;
        acc     = bus.in_valid && reset_n && !hold;
        clr     = flag_clear;
        nop     = '{wr: bus.wr_en, fl: bus.flag_en, dest: bus.dest_addr, res: bus.result,
                    sovf: bus.shift_ovf, aovf: bus.arith_ovf};
        @(posedge clk);
        #1;
        fupd = 1'b0;
        if (rst_now) begin
            foreach (m_regs[i]) m_regs[i] = 8'h00;
            m_flags = 4'h0;
            m_pend.delete();
        end else begin
            if (m_pend.size() > 0) begin
                o = m_pend.pop_front();
                if (o.wr && o.dest != 0) m_regs[o.dest] = o.res;
                if (o.fl) begin
                    fupd    = 1'b1;
                    m_flags = {o.res[7], o.res == 8'h00,
                               (STICKY & m_flags[1]) | o.aovf,
                               (STICKY & m_flags[0]) | o.sovf};
                end
            end
            if (!fupd && STICKY && clr) m_flags = 4'h0;
            if (acc) m_pend.push_back(nop);
        end
    endtask

    task automatic set_op(input bit wr, input bit fl, input logic [2:0] dest,
                          input logic [7:0] res, input bit sovf, input bit aovf);
        bus.in_valid  = 1'b1;
        bus.wr_en     = wr;
        bus.flag_en   = fl;
        bus.dest_addr = dest;
        bus.result    = res;
        bus.shift_ovf = sovf;
        bus.arith_ovf = aovf;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.wr_en    = 1'b0;
        bus.flag_en  = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; hold = 1'b0; flag_clear = 1'b0; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
        idle();
        bus.dest_addr = 3'd0; bus.result = 8'h00; bus.shift_ovf = 1'b0; bus.arith_ovf = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        set_op(1, 0, 3'd3, 8'h55, 0, 0);
        tick();
        idle();
        tick();
        rd_addr_a = 3'd3; rd_addr_b = 3'd0;
        #1;
        total++; if (rd_data_a !== 8'h55) $display("FAIL preload_r3: got %h expected %h", rd_data_a, 8'h55); else passed++;
        reset_n = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready); else passed++;
        for (int c = 0; c < 2; c++) begin
            tick();
            total++; if (commit !== 1'b0) $display("FAIL reset_commit: got %b expected 0", commit); else passed++;
            total++; if (flags !== 4'h0) $display("FAIL reset_flags: got %b expected 0000", flags); else passed++;
            total++; if (rd_data_a !== 8'h00) $display("FAIL reset_r3: got %h expected 00", rd_data_a); else passed++;
            total++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready_hold: got %b expected 0", bus.in_ready); else passed++;
        end
        reset_n = 1'b1;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", bus.in_ready); else passed++;
    endtask

    task automatic test_write_bypass();
        set_op(1, 0, 3'd3, 8'hA5, 0, 0);
        rd_addr_a = 3'd3;
        tick();
        idle();
        #1;
        total++; if (commit !== 1'b1) $display("FAIL write_commit: got %b expected 1", commit); else passed++;
        total++; if (rd_data_a !== 8'hA5) $display("FAIL write_bypass: got %h expected a5", rd_data_a); else passed++;
        tick();
        total++; if (commit !== 1'b0) $display("FAIL write_commit_end: got %b expected 0", commit); else passed++;
        total++; if (rd_data_a !== 8'hA5) $display("FAIL write_file: got %h expected a5", rd_data_a); else passed++;
    endtask

    task automatic test_r0_write();
        set_op(1, 0, 3'd0, 8'hFF, 0, 0);
        rd_addr_a = 3'd0; rd_addr_b = 3'd0;
        tick();
        idle();
        #1;
        total++; if (commit !== 1'b1) $display("FAIL r0_commit: got %b expected 1", commit); else passed++;
        total++; if (rd_data_a !== 8'h00) $display("FAIL r0_bypass_a: got %h expected 00", rd_data_a); else passed++;
        total++; if (rd_data_b !== 8'h00) $display("FAIL r0_bypass_b: got %h expected 00", rd_data_b); else passed++;
        tick();
        total++; if (rd_data_a !== 8'h00) $display("FAIL r0_after: got %h expected 00", rd_data_a); else passed++;
    endtask

    task automatic test_flags();
        set_op(0, 1, 3'd1, 8'h00, 0, 1);
        tick();
        set_op(0, 1, 3'd1, 8'h80, 0, 0);
        tick();
        idle();
        total++; if (flags !== 4'b0110) $display("FAIL flags_zero_ovf: got %b expected 0110", flags); else passed++;
        tick();
        total++; if (flags !== (STICKY ? 4'b1010 : 4'b1000))
            $display("FAIL flags_neg: got %b expected %b", flags, STICKY ? 4'b1010 : 4'b1000); else passed++;
    endtask

    task automatic test_hold();
        set_op(1, 0, 3'd2, 8'h11, 0, 0);
        tick();
        hold = 1'b1;
        set_op(1, 0, 3'd4, 8'h22, 0, 0);
        rd_addr_a = 3'd4; rd_addr_b = 3'd2;
        #1;
        total++; if (commit !== 1'b1) $display("FAIL hold_pending: got %b expected 1", commit); else passed++;
        total++; if (bus.in_ready !== 1'b0) $display("FAIL hold_ready: got %b expected 0", bus.in_ready); else passed++;
        for (int c = 0; c < 3; c++) begin
            tick();
            total++; if (commit !== 1'b0) $display("FAIL hold_commit: got %b expected 0", commit); else passed++;
            total++; if (rd_data_a !== 8'h00) $display("FAIL hold_r4: got %h expected 00", rd_data_a); else passed++;
        end
        hold = 1'b0;
        #1;
        total++; if (bus.in_ready !== 1'b1) $display("FAIL hold_release_ready: got %b expected 1", bus.in_ready); else passed++;
        tick();
        idle();
        #1;
        total++; if (commit !== 1'b1) $display("FAIL hold_release_commit: got %b expected 1", commit); else passed++;
        total++; if (rd_data_a !== 8'h22) $display("FAIL hold_release_bypass: got %h expected 22", rd_data_a); else passed++;
        tick();
        total++; if (rd_data_b !== 8'h11) $display("FAIL hold_r2: got %h expected 11", rd_data_b); else passed++;
    endtask

    task automatic test_reset_mid_op();
        set_op(1, 1, 3'd5, 8'h77, 0, 0);
        rd_addr_a = 3'd5;
        tick();
        idle();
        #1;
        total++; if (commit !== 1'b1) $display("FAIL midrst_pending: got %b expected 1", commit); else passed++;
        reset_n = 1'b0;
        tick();
        total++; if (commit !== 1'b0) $display("FAIL midrst_commit: got %b expected 0", commit); else passed++;
        total++; if (rd_data_a !== 8'h00) $display("FAIL midrst_r5: got %h expected 00", rd_data_a); else passed++;
        total++; if (flags !== 4'h0) $display("FAIL midrst_flags: got %b expected 0000", flags); else passed++;
        reset_n = 1'b1;
        set_op(0, 1, 3'd1, 8'h01, 1, 0);
        tick();
        idle();
        flag_clear = 1'b1;
        tick();
        total++; if (flags !== 4'b0001) $display("FAIL clear_vs_commit: got %b expected 0001", flags); else passed++;
        tick();
        total++; if (flags !== (STICKY ? 4'b0000 : 4'b0001))
            $display("FAIL clear_alone: got %b expected %b", flags, STICKY ? 4'b0000 : 4'b0001); else passed++;
        flag_clear = 1'b0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset_n    = ($urandom_range(0, 59) != 0);
            hold       = ($urandom_range(0, 3) == 0);
            flag_clear = ($urandom_range(0, 7) == 0);
            bus.in_valid  = ($urandom_range(0, 4) != 0);
            bus.wr_en     = $urandom_range(0, 1);
            bus.flag_en   = $urandom_range(0, 1);
            bus.dest_addr = 3'($urandom_range(0, 7));
            bus.result    = 8'($urandom);
            bus.shift_ovf = ($urandom_range(0, 3) == 0);
            bus.arith_ovf = ($urandom_range(0, 3) == 0);
            rd_addr_a     = 3'($urandom_range(0, 7));
            rd_addr_b     = 3'($urandom_range(0, 7));
            #1;
            total++; if (rd_data_a !== exp_read(rd_addr_a))
                $display("FAIL rand_rd_a[%0d] addr %0d: got %h expected %h", c, rd_addr_a, rd_data_a, exp_read(rd_addr_a)); else passed++;
            total++; if (rd_data_b !== exp_read(rd_addr_b))
                $display("FAIL rand_rd_b[%0d] addr %0d: got %h expected %h", c, rd_addr_b, rd_data_b, exp_read(rd_addr_b)); else passed++;
            total++; if (commit !== (m_pend.size() > 0))
                $display("FAIL rand_commit[%0d]: got %b expected %b", c, commit, m_pend.size() > 0); else passed++;
            total++; if (flags !== m_flags)
                $display("FAIL rand_flags[%0d]: got %b expected %b", c, flags, m_flags); else passed++;
            total++; if (bus.in_ready !== (reset_n && !hold))
                $display("FAIL rand_in_ready[%0d]: got %b expected %b", c, bus.in_ready, reset_n && !hold); else passed++;
            tick();
        end
        reset_n = 1'b1; hold = 1'b0; flag_clear = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_r0_write();
        test_flags();
        test_hold();
        test_reset_mid_op();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
